fsm_ctrl_param: RTL



---
 rtl/fsm_ctrl_pkg.sv | 12 +
 rtl/fsm_ctrl_param_idle_debounce.sv | 31 +++
 rtl/fsm_ctrl_param.sv | 116 +++++++++++
 3 files changed

// File: rtl/fsm_ctrl_pkg.sv
// Shared state encoding for the FIFO switch control FSM; also used by the bench to decode state_out.
package fsm_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_RESET  = 3'd0;
  localparam logic [STATE_W-1:0] ST_INIT   = 3'd1;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd2;
  localparam logic [STATE_W-1:0] ST_ACTIVE = 3'd3;
  localparam logic [STATE_W-1:0] ST_ERROR  = 3'd4;

endpackage

// File: rtl/fsm_ctrl_param_idle_debounce.sv
// Saturating count of consecutive all-empty samples; done is combinational on the current sample.
// Latency: done rises in the cycle holding the IDLE_CYCLES-th consecutive all-empty sample; no backpressure.
module idle_debounce
  import fsm_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic all_empty,
  output logic done
);

  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IDLE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // done marks the sample that would bring the count to IDLE_CYCLES, so it never stores that value
  assign done = all_empty && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || !all_empty || done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_ctrl_param.sv
// Control FSM beside the FIFO array: threshold capture in INIT, idle/active tracking, sticky error source.
// Latency: every output is registered or a decode of the state register (1 cycle); no backpressure.
module fsm_ctrl_param
  import fsm_ctrl_pkg::*;
#(
  parameter int N_FIFO      = 5,
  parameter int THR_W       = 2,
  parameter int IDLE_CYCLES = 2,
  parameter int ERR_RECOVER = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [THR_W-1:0]    umbral_mf_in,
  input  logic [THR_W-1:0]    umbral_vc_in,
  input  logic [THR_W-1:0]    umbral_d_in,
  input  logic [N_FIFO-1:0]   fifo_empty,
  input  logic [N_FIFO-1:0]   fifo_error,
  output logic [THR_W-1:0]    umbral_mf_out,
  output logic [THR_W-1:0]    umbral_vc_out,
  output logic [THR_W-1:0]    umbral_d_out,
  output logic [STATE_W-1:0]  state_out,
  output logic [N_FIFO-1:0]   error_src,
  output logic                error_out,
  output logic                active_out,
  output logic                idle_out
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic [THR_W-1:0]   r_mf;
  logic [THR_W-1:0]   r_vc;
  logic [THR_W-1:0]   r_d;
  logic [N_FIFO-1:0]  r_esrc;

  logic w_all_empty;
  logic w_any_err;
  logic w_idle_done;
  logic w_cnt_clear;
  logic w_recover_en;

  assign w_all_empty  = &fifo_empty;
  assign w_any_err    = |fifo_error;
  assign w_recover_en = (ERR_RECOVER != 0);

  // Counting only happens on an ACTIVE edge that neither errors nor re-initialises
  assign w_cnt_clear = (r_state != ST_ACTIVE) || w_any_err || init;

  idle_debounce #(
    .IDLE_CYCLES(IDLE_CYCLES)
  ) u_idle_debounce (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_cnt_clear),
    .all_empty(w_all_empty),
    .done     (w_idle_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET: w_next = ST_INIT;
      ST_INIT: begin
        if (w_any_err)  w_next = ST_ERROR;
        else if (!init) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_any_err)         w_next = ST_ERROR;
        else if (init)         w_next = ST_INIT;
        else if (!w_all_empty) w_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_any_err)        w_next = ST_ERROR;
        else if (init)        w_next = ST_INIT;
        else if (w_idle_done) w_next = ST_IDLE;
      end
      ST_ERROR: begin
        if (w_recover_en && init) w_next = ST_INIT;
      end
      default: w_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RESET;
      r_mf    <= '0;
      r_vc    <= '0;
      r_d     <= '0;
      r_esrc  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_INIT) begin
        r_mf <= umbral_mf_in;
        r_vc <= umbral_vc_in;
        r_d  <= umbral_d_in;
      end
      // Load on entry, accumulate while resident, zero everywhere else (including on recovery)
      if (w_next == ST_ERROR) begin
        r_esrc <= (r_state == ST_ERROR) ? (r_esrc | fifo_error) : fifo_error;
      end else begin
        r_esrc <= '0;
      end
    end
  end

  assign umbral_mf_out = r_mf;
  assign umbral_vc_out = r_vc;
  assign umbral_d_out  = r_d;
  assign state_out     = r_state;
  assign error_src     = r_esrc;
  assign error_out     = (r_state == ST_ERROR);
  assign active_out    = (r_state == ST_ACTIVE);
  assign idle_out      = (r_state == ST_IDLE);

endmodule
